// File: rtl/vexec_pkg.sv
// Shared opcode, flag and stage-1 payload definitions for the vector execute pipe.
package vexec_pkg;

  typedef enum logic [3:0] {
    VADD   = 4'd0,
    VSUB   = 4'd1,
    VMUL   = 4'd2,
    VAND   = 4'd3,
    VOR    = 4'd4,
    VXOR   = 4'd5,
    VSADD  = 4'd6,
    VSMUL  = 4'd7,
    VDOT   = 4'd8,
    VSUM   = 4'd9,
    VMAX   = 4'd10,
    VEXT   = 4'd11,
    VSPLAT = 4'd12,
    VINS   = 4'd13,
    VSHL   = 4'd14,
    VSRA   = 4'd15
  } vop_e;

  localparam int FLAG_W    = 4;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_SAT  = 2;
  localparam int FLAG_RSVD = 3;

  // Width-independent part of the stage-1 payload; lane data and tag sit beside it.
  typedef struct packed {
    vop_e op;
    logic sat;
  } s1_ctrl_t;

endpackage

// File: rtl/vexec_lane.sv
// Combinational single-lane op unit. VEXEC_SAT_EN enables signed clamping of VADD/VSUB/VSADD.
module vexec_lane import vexec_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  vop_e              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] scalar,
  input  logic [SH_W-1:0]   shamt,
  input  logic              sel,
  output logic [DATA_W-1:0] result,
  output logic              sat
);

  logic              is_sub;
  logic [DATA_W-1:0] addend;
  logic [DATA_W-1:0] raw;

  always_comb begin
    is_sub = (op == VSUB);
    addend = (op == VSADD) ? scalar : b;
    raw    = is_sub ? a - addend : a + addend;
  end

`ifdef VEXEC_SAT_EN
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  logic ovf;
  // The true result always carries a's sign when it overflows, so clamp toward that side.
  assign ovf = (raw[DATA_W-1] != a[DATA_W-1]) &&
               (is_sub ? (a[DATA_W-1] != addend[DATA_W-1]) : (a[DATA_W-1] == addend[DATA_W-1]));
`endif

  always_comb begin
    result = '0;
    sat    = 1'b0;
    case (op)
      VADD, VSUB, VSADD: begin
        result = raw;
`ifdef VEXEC_SAT_EN
        if (ovf) begin
          result = a[DATA_W-1] ? MIN_NEG : MAX_POS;
          sat    = 1'b1;
        end
`endif
      end
      VMUL, VDOT:        result = a * b;
      VSMUL:             result = a * scalar;
      VAND:              result = a & b;
      VOR:               result = a | b;
      VXOR:              result = a ^ b;
      VSUM, VMAX, VEXT:  result = a;
      VSPLAT:            result = scalar;
      VINS:              result = sel ? scalar : a;
      VSHL:              result = a << shamt;
      VSRA:              result = $signed(a) >>> shamt;
      default:           result = '0;
    endcase
  end

endmodule

// File: rtl/vector_execute_pipe.sv
// Two-stage vector execute pipe: S1 registers lane results, S2 reduces and drives outputs.
// Saturation (VEXEC_SAT_EN) lives in vexec_lane; here it only feeds flag bit 2.
module vector_execute_pipe import vexec_pkg::*; #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int IMM_W  = 8,
  parameter int TAG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  vop_e                     op,
  input  logic [DATA_W-1:0]        vdata1 [LANES-1:0],
  input  logic [DATA_W-1:0]        vdata2 [LANES-1:0],
  input  logic [DATA_W-1:0]        data1,
  input  logic [IMM_W-1:0]         immediate,
  input  logic [TAG_W-1:0]         tag_in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        vdata_out [LANES-1:0],
  output logic [DATA_W+FLAG_W-1:0] rdata_out,
  output logic [TAG_W-1:0]         tag_out
);

  localparam int IDX_W = $clog2(LANES);
  localparam int SH_W  = $clog2(DATA_W);

  logic [IDX_W-1:0]  lane_idx;
  logic [SH_W-1:0]   shamt;
  logic              unused_imm_bits;
  logic [DATA_W-1:0] lane_res [LANES-1:0];
  logic [LANES-1:0]  lane_sat;

  // Lane selection and shift amount use only the low immediate bits (mod LANES / DATA_W).
  assign lane_idx        = immediate[IDX_W-1:0];
  assign shamt           = immediate[SH_W-1:0];
  assign unused_imm_bits = ^immediate;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vexec_lane #(.DATA_W(DATA_W), .SH_W(SH_W)) u_lane (
      .op     (op),
      .a      (vdata1[g]),
      .b      (vdata2[g]),
      .scalar (data1),
      .shamt  (shamt),
      .sel    (lane_idx == IDX_W'(g)),
      .result (lane_res[g]),
      .sat    (lane_sat[g])
    );
  end

  logic              s1_valid;
  s1_ctrl_t          s1_ctrl;
  logic [DATA_W-1:0] s1_lanes [LANES-1:0];
  logic [DATA_W-1:0] s1_ext;
  logic [TAG_W-1:0]  s1_tag;
  logic              s2_adv;
  logic              s1_load;
  logic              accept;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_adv;
  assign in_ready = s1_load && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_lanes <= '{default: '0};
      s1_ext   <= '0;
      s1_tag   <= '0;
    end else begin
      if (flush)        s1_valid <= 1'b0;
      else if (s1_load) s1_valid <= in_valid;
      if (accept) begin
        s1_ctrl  <= '{op: op, sat: |lane_sat};
        s1_lanes <= lane_res;
        s1_ext   <= vdata1[lane_idx];
        s1_tag   <= tag_in;
      end
    end
  end

  logic [DATA_W-1:0] sum_all;
  logic [DATA_W-1:0] max_all;
  logic [DATA_W-1:0] rout;
  logic [FLAG_W-1:0] flags;

  // LANES-1 adders and comparators folded across the registered lane results.
  always_comb begin
    sum_all = s1_lanes[0];
    max_all = s1_lanes[0];
    for (int i = 1; i < LANES; i++) begin
      sum_all = sum_all + s1_lanes[i];
      if ($signed(s1_lanes[i]) > $signed(max_all)) max_all = s1_lanes[i];
    end
    case (s1_ctrl.op)
      VDOT, VSUM: rout = sum_all;
      VMAX:       rout = max_all;
      VEXT:       rout = s1_ext;
      default:    rout = '0;
    endcase
    flags            = '0;
    flags[FLAG_ZERO] = (rout == '0);
    flags[FLAG_NEG]  = rout[DATA_W-1];
    flags[FLAG_SAT]  = s1_ctrl.sat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      vdata_out <= '{default: '0};
      rdata_out <= '0;
      tag_out   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        vdata_out <= s1_lanes;
        rdata_out <= {flags, rout};
        tag_out   <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_vector_execute_pipe.sv
// Self-checking bench for vector_execute_pipe: queue-based reference model plus directed literal checks.
module tb_vector_execute_pipe;
  import vexec_pkg::*;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int IW    = 8;
  localparam int TW    = 5;
`ifdef VEXEC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic [LANES-1:0][DW-1:0] vec_t;
  typedef struct packed {
    vec_t          v;
    logic [DW+3:0] r;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  vop_e          op;
  logic [DW-1:0] vdata1 [LANES-1:0];
  logic [DW-1:0] vdata2 [LANES-1:0];
  logic [DW-1:0] data1;
  logic [IW-1:0] immediate;
  logic [TW-1:0] tag_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] vdata_out [LANES-1:0];
  logic [DW+3:0] rdata_out;
  logic [TW-1:0] tag_out;

  exp_t          exp_q [$];
  logic [TW-1:0] consumed [$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  vector_execute_pipe #(.LANES(LANES), .DATA_W(DW), .IMM_W(IW), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .vdata1    (vdata1),
    .vdata2    (vdata2),
    .data1     (data1),
    .immediate (immediate),
    .tag_in    (tag_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vdata_out (vdata_out),
    .rdata_out (rdata_out),
    .tag_out   (tag_out)
  );

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic vec_t packOut();
    vec_t p;
    for (int i = 0; i < LANES; i++) p[i] = vdata_out[i];
    return p;
  endfunction

  // Reference: computes the whole result of the op currently on the inputs.
  function automatic exp_t model();
    exp_t          e;
    longint        sa, sb, full;
    logic [DW-1:0] a, b, lane, r, mx;
    bit            satf;
    int            idx, sh;
    e    = '0;
    r    = '0;
    satf = 1'b0;
    idx  = int'(immediate) % LANES;
    sh   = int'(immediate) % DW;
    mx   = vdata1[0];
    for (int i = 0; i < LANES; i++) begin
      a = vdata1[i];
      b = (op == VSADD) ? data1 : vdata2[i];
      lane = '0;
      case (op)
        VADD, VSUB, VSADD: begin
          sa   = longint'($signed(a));
          sb   = longint'($signed(b));
          full = (op == VSUB) ? sa - sb : sa + sb;
          lane = full[DW-1:0];
          if (SAT && full > 64'sd2147483647) begin lane = 32'h7FFF_FFFF; satf = 1'b1; end
          if (SAT && full < -64'sd2147483648) begin lane = 32'h8000_0000; satf = 1'b1; end
        end
        VMUL:    lane = a * b;
        VAND:    lane = a & b;
        VOR:     lane = a | b;
        VXOR:    lane = a ^ b;
        VSMUL:   lane = a * data1;
        VDOT:    begin lane = a * b; r = r + lane; end
        VSUM:    begin lane = a; r = r + a; end
        VMAX:    begin lane = a; if ($signed(a) > $signed(mx)) mx = a; end
        VEXT:    lane = a;
        VSPLAT:  lane = data1;
        VINS:    lane = (i == idx) ? data1 : a;
        VSHL:    lane = a << sh;
        VSRA:    lane = $signed(a) >>> sh;
        default: lane = '0;
      endcase
      e.v[i] = lane;
    end
    if (op == VMAX) r = mx;
    if (op == VEXT) r = vdata1[idx];
    e.r   = {1'b0, satf, r[DW-1], (r == '0), r};
    e.tag = tag_in;
    return e;
  endfunction

  // Every cycle: in_ready against occupancy, and any valid output against the oldest expected result.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      checkOutput("in_ready", 192'(in_ready), 192'(!flush && (exp_q.size() < 2 || out_ready)));
      if (out_valid) begin
        if (exp_q.size() == 0)
          checkOutput("spurious_out", 192'(out_valid), 192'(0));
        else
          checkOutput("out_payload", 192'({packOut(), rdata_out, tag_out}), 192'(exp_q[0]));
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          consumed.push_back(exp_q[0].tag);
          void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(model());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveOp(input vop_e o, input vec_t va, input vec_t vb, input logic [DW-1:0] d1,
                         input logic [IW-1:0] imm, input logic [TW-1:0] tg);
    op = o;
    for (int i = 0; i < LANES; i++) begin
      vdata1[i] = va[i];
      vdata2[i] = vb[i];
    end
    data1     = d1;
    immediate = imm;
    tag_in    = tg;
    in_valid  = 1'b1;
  endtask

  task automatic applyStimulus(input vop_e o, input vec_t va, input vec_t vb, input logic [DW-1:0] d1,
                               input logic [IW-1:0] imm, input logic [TW-1:0] tg);
    bit ok;
    int n;
    driveOp(o, va, vb, d1, imm, tg);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: tag %0d not accepted within 20 cycles", tg);
    end
  endtask

  task automatic waitOut(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL out_timeout: out_valid=0 after %0d cycles, want 1", n);
    end
  endtask

  vec_t va, vb, ev;
  int   lat;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = VADD;
    vdata1    = '{default: '0};
    vdata2    = '{default: '0};
    data1     = '0;
    immediate = '0;
    tag_in    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();

    checkOutput("rst_out_valid", 192'(out_valid), 192'(0));
    checkOutput("rst_vdata", 192'(packOut()), 192'(0));
    checkOutput("rst_rdata", 192'(rdata_out), 192'(0));
    checkOutput("rst_tag", 192'(tag_out), 192'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 192'(in_ready), 192'(1));
    step();

    va = {32'd4, 32'd3, 32'd2, 32'd1};
    vb = {32'd40, 32'd30, 32'd20, 32'd10};
    applyStimulus(VADD, va, vb, 32'd0, 8'd0, 5'd1);
    waitOut(lat);
    checkOutput("vadd_latency", 192'(lat), 192'(2));
    ev = {32'd44, 32'd33, 32'd22, 32'd11};
    checkOutput("vadd_vout", 192'(packOut()), 192'(ev));
    checkOutput("vadd_flags", 192'(rdata_out[35:32]), 192'(4'b0001));
    step();

    applyStimulus(VDOT, va, vb, 32'd0, 8'd0, 5'd2);
    waitOut(lat);
    checkOutput("vdot_rout", 192'(rdata_out[31:0]), 192'(300));
    checkOutput("vdot_flags", 192'(rdata_out[35:32]), 192'(0));
    step();

    applyStimulus(VSADD, {32'd3, 32'd2, 32'd1, 32'h7FFF_FFFF}, vb, 32'd1, 8'd0, 5'd3);
    waitOut(lat);
    checkOutput("vsadd_lane0", 192'(vdata_out[0]), 192'(SAT ? 32'h7FFF_FFFF : 32'h8000_0000));
    checkOutput("vsadd_lane1", 192'(vdata_out[1]), 192'(2));
    checkOutput("vsadd_satflag", 192'(rdata_out[34]), 192'(SAT));
    step();

    applyStimulus(VINS, va, vb, 32'hDEAD, 8'd6, 5'd4);
    waitOut(lat);
    ev = {32'd4, 32'hDEAD, 32'd2, 32'd1};
    checkOutput("vins_vout", 192'(packOut()), 192'(ev));
    step();

    applyStimulus(VEXT, va, vb, 32'd0, 8'd6, 5'd5);
    waitOut(lat);
    checkOutput("vext_rout", 192'(rdata_out[31:0]), 192'(3));
    step();

    applyStimulus(VSRA, {32'd16, 32'h0000_0100, 32'h7000_0000, 32'h8000_0000}, vb, 32'd0, 8'd36, 5'd6);
    waitOut(lat);
    checkOutput("vsra_lane0", 192'(vdata_out[0]), 192'(32'hF800_0000));
    checkOutput("vsra_lane3", 192'(vdata_out[3]), 192'(1));
    step();

    // Backpressure: two ops fill the pipe, the third waits until out_ready returns.
    consumed.delete();
    out_ready = 1'b0;
    applyStimulus(VADD, va, vb, 32'd0, 8'd0, 5'd1);
    applyStimulus(VSUB, va, vb, 32'd0, 8'd0, 5'd2);
    driveOp(VXOR, va, vb, 32'd0, 8'd0, 5'd3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 192'(in_ready), 192'(0));
      checkOutput("stall_tag_held", 192'(tag_out), 192'(1));
      step();
    end
    out_ready = 1'b1;
    applyStimulus(VXOR, va, vb, 32'd0, 8'd0, 5'd3);
    repeat (6) step();
    checkOutput("order_count", 192'(consumed.size()), 192'(3));
    if (consumed.size() == 3)
      checkOutput("order_tags", 192'({consumed[0], consumed[1], consumed[2]}), 192'({5'd1, 5'd2, 5'd3}));

    // Flush with two ops in flight and a third offered alongside the flush.
    out_ready = 1'b0;
    applyStimulus(VADD, va, vb, 32'd0, 8'd0, 5'd7);
    applyStimulus(VADD, va, vb, 32'd0, 8'd0, 5'd8);
    flush = 1'b1;
    driveOp(VOR, va, vb, 32'd0, 8'd0, 5'd9);
    @(negedge clk);
    checkOutput("flush_in_ready", 192'(in_ready), 192'(0));
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", 192'(out_valid), 192'(0));
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("flush_no_stale", 192'(out_valid), 192'(0));
    end
    step();

    // Asynchronous reset with two ops in flight.
    out_ready = 1'b0;
    applyStimulus(VADD, va, vb, 32'd0, 8'd0, 5'd10);
    applyStimulus(VADD, va, vb, 32'd0, 8'd0, 5'd11);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_out_valid", 192'(out_valid), 192'(0));
    checkOutput("rst_mid_tag", 192'(tag_out), 192'(0));
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("rst_no_stale", 192'(out_valid), 192'(0));
    end
    step();

    applyStimulus(VMAX, {32'd2, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFB}, vb, 32'd0, 8'd0, 5'd12);
    waitOut(lat);
    checkOutput("vmax_rout", 192'(rdata_out[31:0]), 192'(3));
    checkOutput("vmax_flags", 192'(rdata_out[35:32]), 192'(0));
    checkOutput("vmax_tag", 192'(tag_out), 192'(12));
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
